rns_to_int_seq: RTL and testbench

- Multi-cycle RNS-to-integer converter. Uses mixed-radix conversion (MRC) with a valid/ready handshake on both sides.
- Packed RNS format is shared with the RNS add/mul and int-to-RNS blocks: 4 byte lanes, lane i holds the residue mod Mi.
- Output is the signed 32-bit integer encoded by the residues. It is bit-exact with the combinational RNS-to-int converter for every valid input.
- Sits at the RNS datapath exit. Replaces the wide CRT multiply/modulo with narrow 8x8 modular steps for timing closure.

---
 rtl/rns_to_int_seq.sv | 169 ++++++++++++++++
 tb/tb_rns_to_int_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rns_to_int_seq.sv
// rns_to_int_seq: multi-cycle RNS -> signed 32-bit integer converter.
// Uses mixed-radix conversion: three narrow modular steps (one 8x8 modular
// multiply per lane per step) and a final Horner reconstruction. This avoids
// the wide CRT multiply/modulo.
//
// Ports:
//   clk, rst              rising-edge clock, async active-high reset
//   in_valid/in_ready     input handshake; rns_in = {r3,r2,r1,r0}, lane i mod Mi
//   out_valid/out_ready   output handshake; int_out/err held stable until taken
//   int_out               two's-complement result (0 when err)
//   err                   some residue ri >= Mi on the accepted input
//
// The sign-mapping macros normally come from common.sv. The fallback values
// below match the default moduli (M = 3368562317).

`ifndef RNS_MIDDLE_POINT
`define RNS_MIDDLE_POINT 32'd1684281159
`endif
`ifndef INT_RNS_DELTA
`define INT_RNS_DELTA 32'd926404979
`endif

// One modular MRC step on one lane: y = ((a - (b mod MOD)) * INV) mod MOD.
module rns_mrc_step #(
  parameter int unsigned MOD = 251,
  parameter int unsigned INV = 1
) (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  logic [7:0]  b_red, d;
  logic [15:0] prod;

  always_comb begin
    // The pivot digit comes from another lane and may exceed this modulus.
    b_red = 8'(32'(b) % MOD);
    // The wrapping 8-bit add is exact: the true result lies in [0, MOD).
    d     = (a >= b_red) ? a - b_red : 8'(a - b_red + 8'(MOD));
    prod  = 16'(d) * 16'(INV);
    y     = 8'(prod % 16'(MOD));
  end
endmodule

module rns_to_int_seq #(
  parameter int unsigned M0 = 251,
  parameter int unsigned M1 = 241,
  parameter int unsigned M2 = 239,
  parameter int unsigned M3 = 233
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] rns_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] int_out,
  output logic        err
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int NUM_PAIRS = NUM_LANES * (NUM_LANES - 1) / 2;

  function automatic int unsigned mod_of(int i);
    case (i)
      0:       return M0;
      1:       return M1;
      2:       return M2;
      default: return M3;
    endcase
  endfunction

  // Brute-force modular inverse. It is evaluated at elaboration only.
  function automatic int unsigned mod_inv(int unsigned a, int unsigned m);
    int unsigned r;
    r = 0;
    for (int unsigned x = 1; x < m; x++)
      if (((a % m) * x) % m == 32'd1) r = x;
    return r;
  endfunction

  // Flat index of the (pivot p, lane j>p) step instance.
  function automatic int pidx(int p, int j);
    return p * (2 * NUM_LANES - p - 1) / 2 + (j - p - 1);
  endfunction

  typedef enum logic [2:0] {IDLE, STEP1, STEP2, STEP3, RECON, DONE} state_t;

  state_t state, state_n;
  logic [NUM_LANES-1:0][VEC_W-1:0] v_r, lanes_in;
  logic [NUM_PAIRS-1:0][VEC_W-1:0] sy;
  logic        err_r, bad_in;
  logic [32:0] x_mr;
  logic [31:0] int_val;

  assign lanes_in = rns_in;

  // Every step result for every pivot. The state machine picks which lanes
  // to overwrite. v_r is reduced in place: after STEP3 it holds v0..v3.
  for (genvar p = 0; p < NUM_LANES - 1; p++) begin : g_piv
    for (genvar j = p + 1; j < NUM_LANES; j++) begin : g_lane
      rns_mrc_step #(
        .MOD(mod_of(j)),
        .INV(mod_inv(mod_of(p) % mod_of(j), mod_of(j)))
      ) u_step (
        .a(v_r[j]),
        .b(v_r[p]),
        .y(sy[pidx(p, j)])
      );
    end
  end

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < NUM_LANES; i++)
      if (32'(lanes_in[i]) >= mod_of(i)) bad_in = 1'b1;
  end

  // Horner form of v0 + M0*(v1 + M1*(v2 + M2*v3)), then the signed fold.
  always_comb begin
    x_mr    = 33'(v_r[0]) + 33'(M0) * (33'(v_r[1]) + 33'(M1) *
              (33'(v_r[2]) + 33'(M2) * 33'(v_r[3])));
    int_val = (x_mr < 33'(`RNS_MIDDLE_POINT)) ? x_mr[31:0]
                                               : x_mr[31:0] + `INT_RNS_DELTA;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = STEP1;
      STEP1:   state_n = STEP2;
      STEP2:   state_n = STEP3;
      STEP3:   state_n = RECON;
      RECON:   state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      v_r     <= '0;
      err_r   <= 1'b0;
      int_out <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (in_valid) begin
          v_r   <= lanes_in;
          err_r <= bad_in;
        end
        STEP1: for (int j = 1; j < NUM_LANES; j++) v_r[j] <= sy[pidx(0, j)];
        STEP2: for (int j = 2; j < NUM_LANES; j++) v_r[j] <= sy[pidx(1, j)];
        STEP3: for (int j = 3; j < NUM_LANES; j++) v_r[j] <= sy[pidx(2, j)];
        RECON: begin
          int_out <= err_r ? '0 : int_val;
          err     <= err_r;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rns_to_int_seq.sv
module tb_rns_to_int_seq;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] rns_in = '0;
  logic        in_ready, out_valid, err;
  logic [31:0] int_out;

  always #5 clk = ~clk;

  rns_to_int_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rns_in(rns_in), .out_valid(out_valid), .out_ready(out_ready),
    .int_out(int_out), .err(err)
  );

  localparam longint unsigned MTOT = 64'd251 * 64'd241 * 64'd239 * 64'd233;
  localparam longint unsigned MID  = (MTOT + 64'd1) / 64'd2;

  int nerr = 0, nchk = 0, cyc = 0;
  bit rnd_bp = 0;

  typedef struct { logic [32:0] exp; int acc; } item_t;
  item_t q[$];
  item_t it;
  logic  exp_ov;

  function automatic longint unsigned modv(int i);
    case (i)
      0:       return 64'd251;
      1:       return 64'd241;
      2:       return 64'd239;
      default: return 64'd233;
    endcase
  endfunction

  function automatic longint unsigned inv_bf(longint unsigned a, longint unsigned m);
    for (longint unsigned x = 1; x < m; x++)
      if ((a * x) % m == 64'd1) return x;
    return 64'd0;
  endfunction

  function automatic logic [31:0] to_rns(longint v);
    longint unsigned x;
    logic [31:0] r;
    x = (v < 0) ? longint'(MTOT) + v : v;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(x % modv(i));
    return r;
  endfunction

  // Reference: range check, then CRT, then fold the upper half to negatives.
  function automatic logic [32:0] model(logic [31:0] r);
    longint unsigned x, ri, mh;
    x = 0;
    for (int i = 0; i < 4; i++)
      if (longint'(r[8*i +: 8]) >= modv(i)) return {1'b1, 32'd0};
    for (int i = 0; i < 4; i++) begin
      ri = longint'(r[8*i +: 8]);
      mh = MTOT / modv(i);
      x  = (x + ri * mh * inv_bf(mh % modv(i), modv(i))) % MTOT;
    end
    if (x >= MID) x = x - MTOT;
    return {1'b0, x[31:0]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Single compare process. Accepts are stamped with their edge number.
  // Outputs must appear exactly 4 edges later and hold until taken.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_int_out", int_out, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
    end else begin
      exp_ov = (q.size() > 0) && (cyc - q[0].acc >= 4);
      chk("in_ready", 32'(in_ready), 32'(q.size() == 0));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (out_valid && exp_ov) begin
        chk("int_out", int_out, q[0].exp[31:0]);
        chk("err", 32'(err), 32'(q[0].exp[32]));
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        it.exp = model(rns_in);
        it.acc = cyc + 1;
        q.push_back(it);
      end
    end
  end

  always @(posedge clk)
    if (rnd_bp) begin
      #1;
      out_ready = ($urandom % 4) != 0;
    end

  // Called just after a rising edge. Returns just after the accepting edge.
  task automatic send(logic [31:0] v);
    int n;
    n = 0;
    in_valid = 1'b1;
    rns_in   = v;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rns_in   = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  logic [31:0] v;
  logic [32:0] m;
  longint      iv;
  int          kind, lane;

  initial begin
    // Hand-derived values that pin the reference model itself.
    chk("inv01", 32'(inv_bf(251 % 241, 241)), 32'd217);
    chk("inv02", 32'(inv_bf(251 % 239, 239)), 32'd20);
    chk("inv03", 32'(inv_bf(251 % 233, 233)), 32'd13);
    chk("inv12", 32'(inv_bf(241 % 239, 239)), 32'd120);
    chk("inv13", 32'(inv_bf(241 % 233, 233)), 32'd204);
    chk("inv23", 32'(inv_bf(239 % 233, 233)), 32'd39);
    chk("rns_1000", to_rns(1000), 32'h442C24F7);
    m = model(32'h442C24F7);   chk("model_1000", m[31:0], 32'h000003E8);
    m = model(32'hE8EEF0FA);   chk("model_m1", m[31:0], 32'hFFFFFFFF);
    m = model(to_rns(longint'(MID) - 1));
    chk("model_mid_m1", m[31:0], 32'd1684281158);
    m = model(to_rns(longint'(MID)));
    chk("model_mid", m[31:0], 32'd2610686138);
    m = model(32'h000000FB);   chk("model_err", 32'(m[32]), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("reset_int_out", int_out, 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors, sent back-to-back.
    send(32'h00000000);
    send(32'h442C24F7);
    send(32'hE8EEF0FA);
    send(to_rns(longint'(MID) - 1));
    send(to_rns(longint'(MID)));
    send(32'h000000FB);
    send(32'h442C24F7);
    drain();

    // Backpressure: hold DONE with a second request pending.
    out_ready = 1'b0;
    send(to_rns(12345));
    fork
      send(32'hE8EEF0FA);
      begin
        repeat (14) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset during STEP2.
    send(32'h442C24F7);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(32'h442C24F7);
    drain();

    // Randomized traffic with random backpressure and input gaps.
    rnd_bp = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      kind = $urandom % 4;
      repeat ($urandom % 3) begin
        @(posedge clk);
        #1;
      end
      for (int i = 0; i < 4; i++) v[8*i +: 8] = 8'($urandom % modv(i));
      case (kind)
        1: begin
          iv = longint'($urandom_range(0, 32'd3368562316)) - 64'sd1684281158;
          v  = to_rns(iv);
          m  = model(v);
          chk("roundtrip", m[31:0], 32'(iv));
        end
        2: begin
          lane = $urandom % 4;
          v[8*lane +: 8] = 8'(modv(lane) + longint'($urandom_range(0, 255 - 32'(modv(lane)))));
        end
        3: v = $urandom;
        default: ;
      endcase
      send(v);
    end
    rnd_bp = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
